// File: rtl/fir_pkg.sv
// Shared FIR types and sizing rules.
//   fir_seq_state_t : sequencer FSM states
//   fir_tag_t       : per-issue tag carried alongside the multiplier latency
//   acc_width()     : accumulator width that cannot overflow over all taps
package fir_pkg;

  typedef enum logic [2:0] {
    CLEAR,
    IDLE,
    ISSUE,
    DRAIN,
    HOLD
  } fir_seq_state_t;

  typedef struct packed {
    logic valid;
    logic first;
    logic last;
  } fir_tag_t;

  // Sum of `taps` products of `multbits` each needs clog2(taps) guard bits.
  function automatic int unsigned acc_width(input int unsigned multbits,
                                            input int unsigned taps);
    return multbits + $clog2(taps);
  endfunction

endpackage

// File: rtl/fir_mac_sequencer_if.sv
// Bus bundle between the MAC sequencer and its sample source, delay-line RAM,
// coefficient ROM, multiplier and result consumer.
//   master : sequencer side (drives in_ready, RAM/ROM addresses, result)
//   slave  : environment side (drives samples, products, out_ready)
interface fir_mac_sequencer_if #(
  parameter int unsigned TAPS     = 33,
  parameter int unsigned DATABITS = 16,
  parameter int unsigned MULTBITS = 32
);
  import fir_pkg::*;

  localparam int unsigned ADDRBITS = $clog2(TAPS);
  localparam int unsigned ACCUBITS = acc_width(MULTBITS, TAPS);

  logic                in_valid;
  logic                in_ready;
  logic [DATABITS-1:0] in_sample;
  logic                wr_en;
  logic [ADDRBITS-1:0] wr_addr;
  logic [DATABITS-1:0] wr_data;
  logic [ADDRBITS-1:0] rd_addr;
  logic [ADDRBITS-1:0] coef_addr;
  logic [MULTBITS-1:0] mult_in;
  logic                out_valid;
  logic                out_ready;
  logic [ACCUBITS-1:0] out_data;

  modport master (
    input  in_valid, in_sample, mult_in, out_ready,
    output in_ready, wr_en, wr_addr, wr_data, rd_addr, coef_addr,
           out_valid, out_data
  );

  modport slave (
    output in_valid, in_sample, mult_in, out_ready,
    input  in_ready, wr_en, wr_addr, wr_data, rd_addr, coef_addr,
           out_valid, out_data
  );

endinterface

// File: rtl/fir_mac_tag_pipe.sv
// Delay line for {valid, first, last} tags so each tag lines up with the
// product that the external RAM/ROM/multiplier path returns DEPTH cycles later.
//   clk, rst_n : clock, synchronous active-low reset (clears all stages)
//   tag_in     : tag for the address pair issued this cycle
//   tag_out    : tag matching the product currently on mult_in
module fir_mac_tag_pipe
  import fir_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic     clk,
  input  logic     rst_n,
  input  fir_tag_t tag_in,
  output fir_tag_t tag_out
);

  fir_tag_t stage_q [DEPTH];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= tag_in;
      for (int unsigned i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign tag_out = stage_q[DEPTH-1];

endmodule

// File: rtl/fir_mac_sequencer.sv
// Time-multiplexed FIR control: one shared multiplier and accumulator walk
// all taps per sample, using an external circular delay-line RAM.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : master side of fir_mac_sequencer_if
//                in_valid/in_ready/in_sample  sample handshake
//                wr_en/wr_addr/wr_data        delay-line write port
//                rd_addr/coef_addr            per-tap read addresses
//                mult_in                      product, MULT_LAT after issue
//                out_valid/out_ready/out_data filtered result handshake
module fir_mac_sequencer
  import fir_pkg::*;
#(
  parameter int unsigned TAPS     = 33,
  parameter int unsigned DATABITS = 16,
  parameter int unsigned MULTBITS = 32,
  parameter int unsigned MULT_LAT = 2
) (
  input logic                 clk,
  input logic                 rst_n,
  fir_mac_sequencer_if.master bus
);

  localparam int unsigned ADDRBITS = $clog2(TAPS);
  localparam int unsigned ACCUBITS = acc_width(MULTBITS, TAPS);
  localparam logic [ADDRBITS-1:0] LAST_ADDR = ADDRBITS'(TAPS - 1);

  fir_seq_state_t      state_q, state_d;
  logic [ADDRBITS-1:0] clr_cnt_q;
  logic [ADDRBITS-1:0] wr_ptr_q;
  logic [ADDRBITS-1:0] rd_addr_q;
  logic [ADDRBITS-1:0] coef_addr_q;
  logic [ACCUBITS-1:0] acc_q;
  logic [ACCUBITS-1:0] mult_ext;
  fir_tag_t            tag_in, tag_out;

  logic                in_ready_c;
  logic                accept_c;
  logic                wr_en_c;
  logic [ADDRBITS-1:0] wr_addr_c;
  logic [DATABITS-1:0] wr_data_c;
  logic                out_valid_c;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= CLEAR;
    else        state_q <= state_d;
  end

  // Next state and handshake/write-port outputs; the write port is driven
  // combinationally so the accepted sample lands in RAM on the accept edge.
  always_comb begin
    state_d     = state_q;
    in_ready_c  = 1'b0;
    accept_c    = 1'b0;
    wr_en_c     = 1'b0;
    wr_addr_c   = '0;
    wr_data_c   = '0;
    out_valid_c = 1'b0;
    unique case (state_q)
      CLEAR: begin
        wr_en_c   = rst_n;
        wr_addr_c = clr_cnt_q;
        if (clr_cnt_q == LAST_ADDR) state_d = IDLE;
      end
      IDLE: begin
        in_ready_c = rst_n;
        accept_c   = rst_n & bus.in_valid;
        if (accept_c) begin
          wr_en_c   = 1'b1;
          wr_addr_c = wr_ptr_q;
          wr_data_c = bus.in_sample;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        if (coef_addr_q == LAST_ADDR) state_d = DRAIN;
      end
      DRAIN: begin
        if (tag_out.valid && tag_out.last) state_d = HOLD;
      end
      HOLD: begin
        out_valid_c = rst_n;
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = CLEAR;
    endcase
  end

  // Counters, write pointer and per-tap address generation. rd_addr counts
  // down from the newest sample and wraps instead of computing a modulo.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      clr_cnt_q   <= '0;
      wr_ptr_q    <= '0;
      rd_addr_q   <= '0;
      coef_addr_q <= '0;
    end else begin
      unique case (state_q)
        CLEAR: begin
          clr_cnt_q <= (clr_cnt_q == LAST_ADDR) ? '0 : clr_cnt_q + ADDRBITS'(1);
        end
        IDLE: begin
          if (accept_c) begin
            rd_addr_q   <= wr_ptr_q;
            coef_addr_q <= '0;
            wr_ptr_q    <= (wr_ptr_q == LAST_ADDR) ? '0 : wr_ptr_q + ADDRBITS'(1);
          end
        end
        ISSUE: begin
          if (coef_addr_q == LAST_ADDR) begin
            rd_addr_q   <= '0;
            coef_addr_q <= '0;
          end else begin
            rd_addr_q   <= (rd_addr_q == '0) ? LAST_ADDR : rd_addr_q - ADDRBITS'(1);
            coef_addr_q <= coef_addr_q + ADDRBITS'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Tag each issued address pair so the returning product is identified.
  always_comb begin
    tag_in       = '0;
    tag_in.valid = (state_q == ISSUE);
    tag_in.first = (state_q == ISSUE) && (coef_addr_q == '0);
    tag_in.last  = (state_q == ISSUE) && (coef_addr_q == LAST_ADDR);
  end

  fir_mac_tag_pipe #(
    .DEPTH (MULT_LAT)
  ) u_tag_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  assign mult_ext = {{(ACCUBITS - MULTBITS){bus.mult_in[MULTBITS-1]}}, bus.mult_in};

  // Accumulator: the first product of a sample restarts the sum.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else if (tag_out.valid) begin
      acc_q <= tag_out.first ? mult_ext : acc_q + mult_ext;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.wr_en     = wr_en_c;
  assign bus.wr_addr   = wr_addr_c;
  assign bus.wr_data   = wr_data_c;
  assign bus.rd_addr   = rd_addr_q;
  assign bus.coef_addr = coef_addr_q;
  assign bus.out_valid = out_valid_c;
  assign bus.out_data  = acc_q;

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Directed bench for fir_mac_sequencer: models a synchronous delay-line RAM,
// a coefficient ROM with coef[k] = k+1 and a registered multiplier (total
// latency 2), and compares against hand-computed results.
module tb_fir_mac_sequencer;
  import fir_pkg::*;

  localparam int unsigned TAPS     = 33;
  localparam int unsigned DATABITS = 16;
  localparam int unsigned MULTBITS = 32;
  localparam int unsigned MULT_LAT = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  fir_mac_sequencer_if #(
    .TAPS     (TAPS),
    .DATABITS (DATABITS),
    .MULTBITS (MULTBITS)
  ) bus ();

  fir_mac_sequencer #(
    .TAPS     (TAPS),
    .DATABITS (DATABITS),
    .MULTBITS (MULTBITS),
    .MULT_LAT (MULT_LAT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // External datapath model
  logic signed [DATABITS-1:0] ram [TAPS];
  logic signed [DATABITS-1:0] rd_data_q;
  logic signed [DATABITS-1:0] coef_q;
  logic                       force_en  = 1'b0;
  logic signed [MULTBITS-1:0] force_val = '0;
  int                         cyc       = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.wr_en) ram[bus.wr_addr] <= bus.wr_data;
    rd_data_q   <= ram[bus.rd_addr];
    coef_q      <= $signed({10'd0, bus.coef_addr}) + 16'sd1;
    bus.mult_in <= force_en ? force_val : rd_data_q * coef_q;
  end

  int n_checks = 0;
  int n_pass   = 0;
  int exp_ptr  = 0;
  bit in_clear_phase = 1'b0;
  bit bad_ov         = 1'b0;

  always @(negedge clk) if (in_clear_phase && bus.out_valid) bad_ov = 1'b1;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Release reset and verify the delay-line clearing sweep.
  task automatic clear_seq();
    int good;
    good = 0;
    rst_n = 1'b1;
    #1;
    for (int i = 0; i < int'(TAPS); i++) begin
      if (bus.wr_en === 1'b1 && int'(bus.wr_addr) == i && bus.wr_data == '0 &&
          bus.in_ready == 1'b0) good++;
      tick();
    end
    check("clear_seq_cycles", good, TAPS);
    check("clear_done_in_ready", bus.in_ready, 1);
    check("clear_done_wr_en", bus.wr_en, 0);
    check("clear_no_out_valid", bad_ov, 0);
    in_clear_phase = 1'b0;
  endtask

  // Push one sample and collect its result; hold>0 applies backpressure.
  task automatic run_sample(input logic signed [DATABITS-1:0] s, input longint exp,
                            input bit chk_addr, input int hold);
    int t, base, waited, good;
    waited = 0;
    while (!bus.in_ready && waited < 100) begin tick(); waited++; end
    check("in_ready_wait", bus.in_ready, 1);
    bus.in_valid  = 1'b1;
    bus.in_sample = s;
    bus.out_ready = (hold == 0);
    #1;
    check("accept_wr_en", bus.wr_en, 1);
    check("accept_wr_addr", bus.wr_addr, exp_ptr);
    check("accept_wr_data", $signed(bus.wr_data), s);
    t       = cyc;
    base    = exp_ptr;
    exp_ptr = (exp_ptr + 1) % TAPS;
    tick();
    bus.in_valid  = 1'b0;
    bus.in_sample = '0;
    check("issue_in_ready_low", bus.in_ready, 0);
    if (chk_addr) begin
      good = 0;
      for (int k = 0; k < int'(TAPS); k++) begin
        if (int'(bus.rd_addr) == (base - k + TAPS) % TAPS && int'(bus.coef_addr) == k)
          good++;
        tick();
      end
      check("issue_addr_seq", good, TAPS);
      check("drain_rd_addr", bus.rd_addr, 0);
      check("drain_coef_addr", bus.coef_addr, 0);
    end
    waited = 0;
    while (!bus.out_valid && waited < 100) begin tick(); waited++; end
    check("out_valid_seen", bus.out_valid, 1);
    check("out_valid_latency", cyc - t, 36);
    check("out_data", longint'($signed(bus.out_data)), exp);
    if (hold > 0) begin
      good = 0;
      for (int i = 0; i < hold; i++) begin
        tick();
        if (bus.out_valid && longint'($signed(bus.out_data)) == exp && !bus.in_ready)
          good++;
      end
      check("hold_stable", good, hold);
      bus.out_ready = 1'b1;
    end
    tick();
    check("post_hs_out_valid", bus.out_valid, 0);
    check("post_hs_in_ready", bus.in_ready, 1);
    if (hold == 0) check("in_ready_latency", cyc - t, 37);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d", n_pass, n_checks);
    $fatal(1);
  end

  initial begin
    int waited;
    bus.in_valid   = 1'b0;
    bus.in_sample  = '0;
    bus.out_ready  = 1'b0;
    in_clear_phase = 1'b1;
    repeat (3) tick();
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_wr_en", bus.wr_en, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_rd_addr", bus.rd_addr, 0);
    check("rst_coef_addr", bus.coef_addr, 0);
    clear_seq();

    // Impulse response walks out the coefficients, then flushes to zero.
    run_sample(16'sd1, 1, 1'b1, 0);
    for (int i = 1; i <= 34; i++) run_sample(16'sd0, (i < 33) ? i + 1 : 0, 1'b0, 0);

    run_sample(16'sd5, 5, 1'b0, 10);

    force_en  = 1'b1;
    force_val = 32'sh7fffffff;
    run_sample(16'sd0, 64'sd70866960351, 1'b0, 0);
    force_val = 32'sh80000000;
    run_sample(16'sd0, -64'sd70866960384, 1'b0, 0);
    force_en  = 1'b0;

    // Reset in the middle of ISSUE.
    waited = 0;
    while (!bus.in_ready && waited < 100) begin tick(); waited++; end
    bus.in_valid  = 1'b1;
    bus.in_sample = 16'sd7;
    tick();
    bus.in_valid  = 1'b0;
    repeat (10) tick();
    check("mid_issue_k", bus.coef_addr, 10);
    in_clear_phase = 1'b1;
    rst_n = 1'b0;
    tick();
    check("mid_rst_out_valid", bus.out_valid, 0);
    check("mid_rst_in_ready", bus.in_ready, 0);
    check("mid_rst_wr_en", bus.wr_en, 0);
    check("mid_rst_coef_addr", bus.coef_addr, 0);
    check("mid_rst_rd_addr", bus.rd_addr, 0);
    tick();
    exp_ptr = 0;
    clear_seq();

    run_sample(16'sd3, 3, 1'b0, 0);
    run_sample(-16'sd2, 4, 1'b0, 0);
    run_sample(16'sd100, 105, 1'b0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fir_mac_sequencer.md
# fir_mac_sequencer

Time-multiplexed FIR control block that shares one multiplier and one accumulator across all taps instead of instantiating TAPS parallel products. It accepts one sample per valid/ready handshake and writes it into an external circular sample delay-line RAM. It then issues one (sample address, coefficient address) pair per cycle to the external RAM/ROM/multiplier path, accumulates the returning products, and presents the filtered result on a valid/ready output.

## Interface
- TAPS, 33, filter length (number of sample and coefficient words)
- DATABITS, 16, input sample width (signed)
- MULTBITS, 32, product width returned by external multiplier (signed)
- MULT_LAT, 2, cycles from rd_addr/coef_addr issue to matching product on mult_in (≥1)
- ADDRBITS, $clog2(TAPS), derived; not overridden
- ACCUBITS, MULTBITS + $clog2(TAPS), derived; not overridden
- clk  in  1  single clock; all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- in_valid  in  1  sample offered
- in_ready  out  1  block can accept a sample
- in_sample  in  DATABITS  sample data
- wr_en  out  1  delay-line RAM write strobe
- wr_addr  out  ADDRBITS  delay-line write address
- wr_data  out  DATABITS  delay-line write data
- rd_addr  out  ADDRBITS  delay-line read address
- coef_addr  out  ADDRBITS  coefficient ROM address
- mult_in  in  MULTBITS  product returned MULT_LAT cycles after issue
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- out_data  out  ACCUBITS  signed filter output

## Operation
- FSM states: CLEAR, IDLE, ISSUE, DRAIN, HOLD.
- CLEAR:
  - Entered whenever rst_n is low.
  - After release, runs TAPS cycles with wr_en=1, wr_addr=0..TAPS-1, wr_data=0.
  - Then goes to IDLE with wr_ptr=0.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready, combinationally drives wr_en=1, wr_addr=wr_ptr, wr_data=in_sample.
  - Latches base=wr_ptr and advances wr_ptr (TAPS-1 wraps to 0).
  - Goes to ISSUE.
- ISSUE:
  - TAPS cycles, k=0..TAPS-1.
  - Drives coef_addr=k and rd_addr=(base−k) mod TAPS; rd_addr is a down-counter wrapping 0→TAPS-1, with no divider.
  - After k=TAPS-1, goes to DRAIN.
- DRAIN:
  - Waits until the last tagged product has been accumulated, then goes to HOLD.
- Tag pipeline:
  - A MULT_LAT-deep shift register carries {valid, first, last} alongside each issue.
  - When a tagged product arrives with first: acc = sext(mult_in).
  - Otherwise: acc += sext(mult_in).
  - mult_in is ignored when its tag is not valid.
- HOLD:
  - out_valid=1 and out_data=acc, both stable until out_ready.
  - On out_valid&out_ready, goes to IDLE.
- in_ready=0 in every state except IDLE, and while rst_n is low.
- Arithmetic:
  - Two's complement throughout; ACCUBITS sizing makes overflow impossible.
  - No rounding or truncation; scaling is done downstream.
- Outputs are undriven-don't-care only for rd_addr/coef_addr outside ISSUE; these are held at 0.

## Timing
- Reset values, with rst_n low at an edge:
  - in_ready, wr_en, out_valid = 0.
  - out_data, acc, wr_ptr, rd_addr, coef_addr = 0.
  - Tag pipeline cleared.
  - State CLEAR.
- Accept at cycle t; ISSUE occupies cycles t+1..t+TAPS.
- Last product on mult_in at t+TAPS+MULT_LAT; out_valid rises at t+TAPS+MULT_LAT+1 (36 with defaults).
- With out_ready held high, in_ready returns at t+TAPS+MULT_LAT+2. Minimum sample period is TAPS+MULT_LAT+2 cycles.
- Write/read ordering: the sample written at cycle t is read at t+1, so the external RAM must use a synchronous write.
- Reset mid-operation: the next edge discards in-flight tags, drops out_valid and restarts CLEAR. No partial result is ever emitted.
- out_ready high outside HOLD has no effect. in_valid outside IDLE is not accepted and must be held by the source.

## Structure
- Shared package fir_pkg:
  - typedef enum fir_seq_state_t {CLEAR, IDLE, ISSUE, DRAIN, HOLD}.
  - Function acc_width(multbits, taps).
  - The accumulator and other FIR blocks reuse the same ACCUBITS rule.
- Sub-module fir_mac_tag_pipe: parameterised MULT_LAT shift register of {valid, first, last}, cleared on reset.
- The remaining logic (FSM, counters, wr_ptr, accumulator) stays in fir_mac_sequencer.

## Test plan
- Bench models: synchronous RAM plus registered multiplier with total latency MULT_LAT=2; coef[k]=k+1.
- Reset release -> wr_en=1 for exactly 33 cycles, wr_addr 0..32, wr_data 0; in_ready=1 on the 34th cycle; out_valid never asserted.
- Impulse: sample 1 followed by 34 zeros -> successive out_data 1,2,…,33, then 0.
- Latency: accept at cycle t -> out_valid first high at t+36; with out_ready=1, in_ready high at t+37 and rd_addr sequence base, base−1, … wrapping 0→32.
- Backpressure: out_ready low for 10 cycles in HOLD -> out_valid=1 and out_data unchanged throughout, in_ready=0, exactly one handshake after release.
- Extremes: mult_in forced to 2^31−1 on every tap -> out_data=70866960351; forced to −2^31 -> out_data=−70866960384.
- Reset mid-ISSUE (rst_n low at k=10) -> out_valid stays 0, CLEAR sequence restarts from addr 0, and the first post-reset output reflects only post-reset samples.
